// File: rtl/fetch_entry_rx.sv
// Two-entry fetch-to-decode buffer. Stops issuing after a faulting entry has
// been handed to decode and waits for a flush before it issues again.
module fetch_entry_rx #(
  parameter int VLEN = 64,
  parameter int CF_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  input  logic [31:0]     fetch_instr_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  input  logic            fetch_ex_i,
  input  logic [CF_W-1:0] fetch_cf_i,
  input  logic [VLEN-1:0] fetch_pred_addr_i,
  output logic            fetch_ready_o,
  output logic            issue_valid_o,
  output logic [31:0]     issue_instr_o,
  output logic [VLEN-1:0] issue_addr_o,
  output logic            issue_ex_o,
  output logic [CF_W-1:0] issue_cf_o,
  output logic [VLEN-1:0] issue_pred_addr_o,
  output logic            issue_compressed_o,
  input  logic            issue_ready_i,
  output logic [1:0]      occupancy_o,
  output logic            ex_hold_o,
  output logic [31:0]     issued_cnt_o
);

  typedef enum logic {RUN, HOLD} state_e;

  state_e          r_state, w_state_nxt;
  logic [31:0]     r_instr [2];
  logic [VLEN-1:0] r_addr  [2];
  logic [VLEN-1:0] r_pred  [2];
  logic            r_ex    [2];
  logic [CF_W-1:0] r_cf    [2];
  logic            r_wr_ptr, r_rd_ptr;
  logic [1:0]      r_occ;
  logic [31:0]     r_issued_cnt;
  logic            w_push, w_pop, w_empty;

  // Handshakes depend on registered occupancy only, so ready never follows issue_ready_i.
  assign w_empty       = (r_occ == 2'd0);
  assign fetch_ready_o = (r_occ != 2'd2);
  assign w_push        = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign issue_valid_o = ~w_empty & (r_state == RUN) & ~flush_i;
  assign w_pop         = issue_valid_o & issue_ready_i;

  assign issue_instr_o      = w_empty ? '0 : r_instr[r_rd_ptr];
  assign issue_addr_o       = w_empty ? '0 : r_addr[r_rd_ptr];
  assign issue_ex_o         = w_empty ? 1'b0 : r_ex[r_rd_ptr];
  assign issue_cf_o         = w_empty ? '0 : r_cf[r_rd_ptr];
  assign issue_pred_addr_o  = w_empty ? '0 : r_pred[r_rd_ptr];
  assign issue_compressed_o = (issue_instr_o[1:0] != 2'b11);
  assign occupancy_o        = r_occ;
  assign ex_hold_o          = (r_state == HOLD);
  assign issued_cnt_o       = r_issued_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)                 w_state_nxt = RUN;
    else if (w_pop && issue_ex_o) w_state_nxt = HOLD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ        <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_issued_cnt <= 32'd0;
    end else begin
      if (w_pop) r_issued_cnt <= r_issued_cnt + 32'd1;
      if (flush_i) begin
        r_occ    <= 2'd0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  // Payload storage carries no reset; empty slots are masked at the outputs.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= fetch_instr_i;
      r_addr[r_wr_ptr]  <= fetch_addr_i;
      r_ex[r_wr_ptr]    <= fetch_ex_i;
      r_cf[r_wr_ptr]    <= fetch_cf_i;
      r_pred[r_wr_ptr]  <= fetch_pred_addr_i;
    end
  end

endmodule

// File: tb/tb_fetch_entry_rx.sv
// Bench for fetch_entry_rx: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_entry_rx;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        ex;
    logic [2:0]  cf;
    logic [63:0] pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_instr_i = '0;
  logic [63:0] fetch_addr_i = '0;
  logic        fetch_ex_i = 1'b0;
  logic [2:0]  fetch_cf_i = '0;
  logic [63:0] fetch_pred_addr_i = '0;
  logic        issue_ready_i = 1'b0;
  logic        fetch_ready_o, issue_valid_o, issue_ex_o, issue_compressed_o, ex_hold_o;
  logic [31:0] issue_instr_o, issued_cnt_o;
  logic [63:0] issue_addr_o, issue_pred_addr_o;
  logic [2:0]  issue_cf_o;
  logic [1:0]  occupancy_o;

  int n_chk = 0;
  int n_pass = 0;

  ent_t        m_q[$];
  logic        m_hold = 1'b0;
  logic [31:0] m_cnt = '0;
  logic        preload = 1'b0;

  fetch_entry_rx #(.VLEN(64), .CF_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i),
    .fetch_addr_i(fetch_addr_i), .fetch_ex_i(fetch_ex_i), .fetch_cf_i(fetch_cf_i),
    .fetch_pred_addr_i(fetch_pred_addr_i), .fetch_ready_o(fetch_ready_o),
    .issue_valid_o(issue_valid_o), .issue_instr_o(issue_instr_o),
    .issue_addr_o(issue_addr_o), .issue_ex_o(issue_ex_o), .issue_cf_o(issue_cf_o),
    .issue_pred_addr_o(issue_pred_addr_o), .issue_compressed_o(issue_compressed_o),
    .issue_ready_i(issue_ready_i), .occupancy_o(occupancy_o),
    .ex_hold_o(ex_hold_o), .issued_cnt_o(issued_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: a plain queue, a hold flag and a counter.
  always @(posedge clk or negedge rst_ni) begin : model
    ent_t cur;
    logic do_pop, do_push;
    if (!rst_ni) begin
      m_q.delete();
      m_hold = 1'b0;
      m_cnt  = '0;
    end else if (flush_i) begin
      m_q.delete();
      m_hold = 1'b0;
    end else begin
      cur     = '{fetch_instr_i, fetch_addr_i, fetch_ex_i, fetch_cf_i, fetch_pred_addr_i};
      do_pop  = (m_q.size() != 0) && !m_hold && issue_ready_i;
      do_push = fetch_valid_i && (m_q.size() != 2);
      if (do_pop) begin
        if (m_q[0].ex) m_hold = 1'b1;
        m_cnt = m_cnt + 32'd1;
        void'(m_q.pop_front());
      end
      if (do_push) m_q.push_back(cur);
      if (preload) m_cnt = 32'hFFFF_FFFF;
    end
  end

  always @(negedge clk) begin : compare
    int   occ;
    ent_t h;
    occ = m_q.size();
    h   = (occ != 0) ? m_q[0] : '0;
    chk("fetch_ready", 256'(fetch_ready_o), 256'(occ != 2));
    chk("issue_valid", 256'(issue_valid_o), 256'((occ != 0) && !m_hold && !flush_i));
    chk("issue_fields", 256'({issue_instr_o, issue_addr_o, issue_ex_o, issue_cf_o, issue_pred_addr_o}),
        256'(h));
    chk("compressed", 256'(issue_compressed_o), 256'(h.instr[1:0] != 2'b11));
    chk("occupancy", 256'(occupancy_o), 256'(occ));
    chk("ex_hold", 256'(ex_hold_o), 256'(m_hold));
    chk("issued_cnt", 256'(issued_cnt_o), 256'(m_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] a, input logic ex);
    fetch_valid_i     = v;
    fetch_instr_i     = ins;
    fetch_addr_i      = a;
    fetch_ex_i        = ex;
    fetch_cf_i        = 3'(ins[4:2]);
    fetch_pred_addr_i = a + 64'd4;
  endtask

  initial begin
    // Reset values
    rst_ni = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_ready", 256'(fetch_ready_o), 256'(1));
    chk("rst_valid", 256'(issue_valid_o), 256'(0));
    chk("rst_instr", 256'(issue_instr_o), 256'(0));
    chk("rst_occ", 256'(occupancy_o), 256'(0));
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Single push, immediate issue
    issue_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0013, 64'h8000_0000, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("d1_valid", 256'(issue_valid_o), 256'(1));
    chk("d1_instr", 256'(issue_instr_o), 256'(32'h13));
    chk("d1_addr", 256'(issue_addr_o), 256'(64'h8000_0000));
    chk("d1_compressed", 256'(issue_compressed_o), 256'(0));
    cyc();
    @(negedge clk);
    chk("d1_cnt", 256'(issued_cnt_o), 256'(1));
    chk("d1_occ", 256'(occupancy_o), 256'(0));
    cyc();

    // Fill with decode stalled, third push rejected, then drain in order
    issue_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0093, 64'h100, 1'b0); cyc();
    drive(1'b1, 32'h0000_0113, 64'h104, 1'b0); cyc();
    drive(1'b1, 32'h0000_0193, 64'h108, 1'b0);
    @(negedge clk);
    chk("d2_ready_full", 256'(fetch_ready_o), 256'(0));
    chk("d2_occ", 256'(occupancy_o), 256'(2));
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    issue_ready_i = 1'b1;
    @(negedge clk);
    chk("d2_first", 256'(issue_instr_o), 256'(32'h93));
    cyc();
    @(negedge clk);
    chk("d2_second", 256'(issue_instr_o), 256'(32'h113));
    cyc();
    @(negedge clk);
    chk("d2_empty", 256'(occupancy_o), 256'(0));
    chk("d2_cnt", 256'(issued_cnt_o), 256'(3));
    cyc();

    // Faulting entry issued, follower held until flush
    drive(1'b1, 32'h0000_0213, 64'h200, 1'b1); cyc();
    drive(1'b1, 32'h0000_0293, 64'h204, 1'b0);
    @(negedge clk);
    chk("d3_ex", 256'(issue_ex_o), 256'(1));
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("d3_hold", 256'(ex_hold_o), 256'(1));
    chk("d3_valid", 256'(issue_valid_o), 256'(0));
    chk("d3_held", 256'(issue_instr_o), 256'(32'h293));
    cyc(); cyc();
    @(negedge clk);
    chk("d3_still", 256'(occupancy_o), 256'(1));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    @(negedge clk);
    chk("d3_released", 256'(ex_hold_o), 256'(0));
    chk("d3_flushed", 256'(occupancy_o), 256'(0));
    cyc();

    // Flush on a full buffer with a simultaneous push
    issue_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0313, 64'h300, 1'b0); cyc();
    drive(1'b1, 32'h0000_0393, 64'h304, 1'b0); cyc();
    flush_i = 1'b1;
    issue_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0413, 64'h308, 1'b0);
    cyc();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("d4_occ", 256'(occupancy_o), 256'(0));
    chk("d4_cnt", 256'(issued_cnt_o), 256'(4));
    chk("d4_valid", 256'(issue_valid_o), 256'(0));
    cyc();

    // Compressed encoding, then reset with an entry buffered
    drive(1'b1, 32'h0000_4501, 64'h400, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("d5_compressed", 256'(issue_compressed_o), 256'(1));
    chk("d5_instr", 256'(issue_instr_o), 256'(32'h4501));
    cyc();
    issue_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0513, 64'h500, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("d5_occ1", 256'(occupancy_o), 256'(1));
    #1 rst_ni = 1'b0;
    #1;
    chk("d5_rst_occ", 256'(occupancy_o), 256'(0));
    chk("d5_rst_valid", 256'(issue_valid_o), 256'(0));
    chk("d5_rst_instr", 256'(issue_instr_o), 256'(0));
    chk("d5_rst_cnt", 256'(issued_cnt_o), 256'(0));
    chk("d5_rst_ready", 256'(fetch_ready_o), 256'(1));
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      fetch_cf_i        = 3'($urandom_range(0, 7));
      fetch_pred_addr_i = {$urandom, $urandom};
      issue_ready_i     = $urandom_range(0, 3) != 0;
      flush_i           = $urandom_range(0, 24) == 0;
      cyc();
    end

    // Counter wrap
    flush_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    issue_ready_i = 1'b0;
    cyc();
    flush_i = 1'b0;
    preload = 1'b1;
    cyc();
    preload = 1'b0;
    force dut.r_issued_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_issued_cnt;
    @(negedge clk);
    chk("d6_preload", 256'(issued_cnt_o), 256'(32'hFFFF_FFFF));
    cyc();
    issue_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0613, 64'h600, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    @(negedge clk);
    chk("d6_wrap", 256'(issued_cnt_o), 256'(0));
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
